instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 1024, instruction memory size in bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  byte address driven to instruction memory.
REQ-006 SHALL have port imem_data  input  32  little-endian instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port stall  input  1  decode cannot accept; hold PC and IF/ID register.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port if_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 SHALL have port if_pc  output  32  address of if_instr.
REQ-012 SHALL have port if_instr  output  32  fetched instruction.
REQ-013 SHALL have port if_pc_plus4  output  32  if_pc + 4, for JAL/JALR link.
REQ-014 SHALL have port fetch_fault  output  1  sticky fault: misaligned or out-of-range PC.

Function
REQ-015 SHALL hold a 32-bit PC register; imem_addr SHALL equal PC combinationally, with no added latency.
REQ-016 SHALL implement FSM states BOOT, RUN, HALT; reset enters BOOT.
REQ-017 BOOT: if_valid=0, no capture; BOOT SHALL go to RUN on the next edge unconditionally.
REQ-018 RUN, no stall, no redirect, PC legal: on the edge, IF/ID SHALL capture {PC, imem_data, PC+4}, if_valid<=1, and PC<=PC+4.
REQ-019 RUN, stall=1, no redirect: PC and IF/ID (including if_valid) SHALL hold unchanged.
REQ-020 RUN, redirect_valid=1: PC<=redirect_pc and if_valid<=0 (flush); redirect SHALL take priority over stall.
REQ-021 Steady-state throughput SHALL be one instruction per cycle; first valid instruction SHALL appear 2 edges after rst deasserts.
REQ-022 PC is illegal when PC[1:0]!=0 or PC > IMEM_BYTES-4; in RUN with illegal PC and no redirect, the block SHALL set fetch_fault<=1, set if_valid<=0, hold PC, and enter HALT.
REQ-023 A redirect to an illegal target SHALL be accepted into PC; the fault SHALL be raised on the following RUN cycle per REQ-022.
REQ-024 HALT: PC, if_valid=0 and fetch_fault=1 SHALL hold regardless of stall/redirect; exit only by rst.
REQ-025 PC+4 SHALL be 32-bit modulo arithmetic (32'hFFFF_FFFC+4 = 0), but the range check SHALL fault before any wrap is fetched.
REQ-026 Stall and redirect SHALL be ignored in BOOT and HALT.

Reset
REQ-027 On rst=1 at an edge: PC<=RESET_PC, state<=BOOT, if_valid<=0, if_pc<=0, if_instr<=32'h0000_0013 (NOP), if_pc_plus4<=0, fetch_fault<=0.
REQ-028 rst asserted mid-operation (any state, including during stall or redirect) SHALL override all other inputs on that edge.

Verification
REQ-029 Memory preloaded with 00000f93, 00f00313, 001f8f93 at 0/4/8; release rst -> edge 2: if_valid=1, if_pc=0, if_instr=00000f93; edge 3: if_pc=4, if_instr=00f00313, if_pc_plus4=8.
REQ-030 stall=1 for 3 cycles while if_pc=4 -> if_pc=4 and imem_addr=8 held for 3 cycles; after release, next edge if_pc=8.
REQ-031 redirect_valid=1, redirect_pc=0x18, stall=1 on the same cycle -> next edge if_valid=0, imem_addr=0x18; edge after, if_pc=0x18, if_valid=1.
REQ-032 redirect_pc=0x06 -> PC=0x06 for one cycle, then fetch_fault=1, if_valid=0; subsequent redirects to 0x0 are ignored until rst.
REQ-033 Sequential fetch to 0x3FC (IMEM_BYTES=1024) -> 0x3FC delivered valid; PC=0x400 then faults, HALT entered.
REQ-034 rst pulsed while stall=1 and if_valid=1 -> next edge if_valid=0, imem_addr=RESET_PC, fetch_fault=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives instruction memory and
// fills the IF/ID pipeline register. Illegal PCs (misaligned or beyond
// the end of instruction memory) latch a sticky fault and park the stage
// in HALT until the next reset.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    // Highest byte address that still holds a complete instruction word.
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_BYTES - 4);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic        pc_legal;
    logic [31:0] pc_next_seq;

    // The range check runs on the current PC, so a wrapped PC+4 is never fetched.
    assign pc_legal    = (pc_q[1:0] == 2'b00) && (pc_q <= PC_LIMIT);
    assign pc_next_seq = pc_q + 32'd4;

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign fetch_fault = fetch_fault_q;

    // Next-state and datapath control: redirect beats fault check beats stall.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_pc_plus4_d = if_pc_plus4_q;
        fetch_fault_d = fetch_fault_q;
        case (state_q)
            BOOT: begin
                state_d    = RUN;
                if_valid_d = 1'b0;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                end else if (!pc_legal) begin
                    fetch_fault_d = 1'b1;
                    if_valid_d    = 1'b0;
                    state_d       = HALT;
                end else if (!stall) begin
                    if_pc_d       = pc_q;
                    if_instr_d    = imem_data;
                    if_pc_plus4_d = pc_next_seq;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_next_seq;
                end
            end
            HALT: begin
                if_valid_d    = 1'b0;
                fetch_fault_d = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and pipeline registers; synchronous reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_instr_q    <= NOP;
            if_pc_plus4_q <= 32'h0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table,
// an end-of-memory sequence, and randomized traffic against a reference model.
module tb_instruction_fetch;

    localparam int unsigned IMEM_BYTES = 1024;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        fetch_fault;

    logic [31:0] mem [256];

    int tests_run;
    int tests_failed;

    // Reference model state: a fetch stage described as "booting", "faulted" and registers.
    logic        m_boot;
    logic        m_fault;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_if_pc;
    logic [31:0] m_instr;
    logic [31:0] m_plus4;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_plus4;
        logic [31:0] e_addr;
        logic        e_fault;
    } vec_t;

    vec_t vecs [18];

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .IMEM_BYTES(IMEM_BYTES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_pc_plus4   (if_pc_plus4),
        .fetch_fault   (fetch_fault)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a < 32'(IMEM_BYTES))
            return mem[a[9:2]];
        else
            return 32'hBAD0_0000 ^ a;
    endfunction

    // Combinational instruction memory.
    always_comb begin
        imem_data = mem_read(imem_addr);
    end

    task automatic check_output(input string name, input logic ev, input logic [31:0] epc,
                                input logic [31:0] einstr, input logic [31:0] eplus4,
                                input logic [31:0] eaddr, input logic efault);
        tests_run++;
        if (if_valid !== ev || if_pc !== epc || if_instr !== einstr ||
            if_pc_plus4 !== eplus4 || imem_addr !== eaddr || fetch_fault !== efault) begin
            tests_failed++;
            $display("[TB] FAIL %s: got valid=%b pc=%h instr=%h plus4=%h addr=%h fault=%b, want valid=%b pc=%h instr=%h plus4=%h addr=%h fault=%b",
                     name, if_valid, if_pc, if_instr, if_pc_plus4, imem_addr, fetch_fault,
                     ev, epc, einstr, eplus4, eaddr, efault);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic s, input logic v, input logic [31:0] t);
        rst            = r;
        stall          = s;
        redirect_valid = v;
        redirect_pc    = t;
        @(posedge clk);
        #1;
    endtask

    // One cycle of the reference model, then compare the DUT with it.
    task automatic model_step(input string name, input logic r, input logic s,
                              input logic v, input logic [31:0] t);
        longint unsigned pc_l;
        pc_l = longint'(m_pc);
        if (r) begin
            m_boot  = 1'b1;
            m_fault = 1'b0;
            m_pc    = RESET_PC;
            m_valid = 1'b0;
            m_if_pc = 32'h0;
            m_instr = 32'h0000_0013;
            m_plus4 = 32'h0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_fault) begin
            m_valid = 1'b0;
        end else if (v) begin
            m_pc    = t;
            m_valid = 1'b0;
        end else if ((pc_l % 4) != 0 || pc_l + 4 > longint'(IMEM_BYTES)) begin
            m_fault = 1'b1;
            m_valid = 1'b0;
        end else if (!s) begin
            m_if_pc = m_pc;
            m_instr = mem_read(m_pc);
            m_plus4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
        apply_stimulus(r, s, v, t);
        check_output(name, m_valid, m_if_pc, m_instr, m_plus4, m_pc, m_fault);
    endtask

    initial begin
        logic [31:0] tgt;
        int          sel;
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        m_boot = 1'b1; m_fault = 1'b0; m_pc = RESET_PC; m_valid = 1'b0;
        m_if_pc = 32'h0; m_instr = 32'h0000_0013; m_plus4 = 32'h0;

        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h0000_0f93;
        mem[1] = 32'h00f0_0313;
        mem[2] = 32'h001f_8f93;

        //           rst   stall rv    rpc          valid pc           instr          plus4        addr         fault
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0013, 32'h0,       32'h0,       1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0013, 32'h0,       32'h0,       1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       32'h0000_0f93, 32'h4,       32'h4,       1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h4,       32'h00f0_0313, 32'h8,       32'h8,       1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h4,       32'h00f0_0313, 32'h8,       32'h8,       1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h4,       32'h00f0_0313, 32'h8,       32'h8,       1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h4,       32'h00f0_0313, 32'h8,       32'h8,       1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h8,       32'h001f_8f93, 32'hC,       32'hC,       1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h18,      1'b0, 32'h8,       32'h001f_8f93, 32'hC,       32'h18,      1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h18,      32'h1000_0006, 32'h1C,      32'h1C,      1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h6,       1'b0, 32'h18,      32'h1000_0006, 32'h1C,      32'h6,       1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h18,      32'h1000_0006, 32'h1C,      32'h6,       1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h0,       1'b0, 32'h18,      32'h1000_0006, 32'h1C,      32'h6,       1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h0,       1'b0, 32'h18,      32'h1000_0006, 32'h1C,      32'h6,       1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0013, 32'h0,       32'h0,       1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0013, 32'h0,       32'h0,       1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       32'h0000_0f93, 32'h4,       32'h4,       1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h18,      1'b0, 32'h0,       32'h0000_0013, 32'h0,       32'h0,       1'b0};

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc);
            check_output($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                         vecs[i].e_plus4, vecs[i].e_addr, vecs[i].e_fault);
        end

        // Walk sequentially to the last word of memory, then into the fault.
        m_boot = 1'b1; m_fault = 1'b0; m_pc = RESET_PC; m_valid = 1'b0;
        m_if_pc = 32'h0; m_instr = 32'h0000_0013; m_plus4 = 32'h0;
        model_step("seq_rst", 1'b1, 1'b0, 1'b0, 32'h0);
        model_step("seq_boot", 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 256; i++) model_step("seq_fetch", 1'b0, 1'b0, 1'b0, 32'h0);
        check_output("last_word", 1'b1, 32'h3FC, mem[255], 32'h400, 32'h400, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check_output("range_fault", 1'b0, 32'h3FC, mem[255], 32'h400, 32'h400, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0);
        check_output("halt_holds", 1'b0, 32'h3FC, mem[255], 32'h400, 32'h400, 1'b1);

        // Randomized traffic against the reference model.
        m_boot = 1'b1; m_fault = 1'b0; m_pc = RESET_PC; m_valid = 1'b0;
        m_if_pc = 32'h0; m_instr = 32'h0000_0013; m_plus4 = 32'h0;
        model_step("rand_rst", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                7:       tgt = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
                8:       tgt = 32'h400 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                9:       tgt = 32'hFFFF_FFFC;
                default: tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            model_step("rand",
                       ($urandom_range(0, 99) < 3),
                       ($urandom_range(0, 99) < 30),
                       ($urandom_range(0, 99) < 10),
                       tgt);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
